// File: rtl/fetch_pc_unit.sv
// Fetch PC register and IF/ID pipeline register for the five-stage MIPS core.
// Optional FETCH_PERF_CNT_EN adds taken-redirect and stall event counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI   = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_F,
    input  logic        br_en,
    input  logic        branch,
    input  logic [15:0] br_off,
    input  logic        jump_en,
    input  logic [25:0] jump_idx,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_F,
    output logic [31:0] pc_D,
    output logic [31:0] pc8_D,
    output logic [31:0] instr_D,
    output logic        bd_D,
    output logic [4:0]  exc_D
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] taken_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] fpc_q, fpc_d;
    logic [31:0] dpc_q, dpc_d;
    logic [31:0] dinstr_q, dinstr_d;
    logic        dbd_q, dbd_d;
    logic [4:0]  dexc_q, dexc_d;

    logic [31:0] pc4_D;
    logic [31:0] br_target;
    logic [31:0] jump_target;
    logic        flush;
    logic        hold;
    logic        redirect;
    logic        fetch_fault;

    // Target computation, all relative to the D-stage instruction.
    always_comb begin
        pc4_D       = dpc_q + 32'd4;
        br_target   = pc4_D + {{14{br_off[15]}}, br_off, 2'b00};
        jump_target = {pc4_D[31:28], jump_idx, 2'b00};
    end

    always_comb begin
        flush       = exc_req | eret_req;
        hold        = stall & ~flush;
        redirect    = ~flush & ~stall & ((br_en & branch) | jump_en | jr_en);
        fetch_fault = (fpc_q[1:0] != 2'b00) || (fpc_q < IMEM_LO) || (fpc_q > IMEM_HI);
    end

    always_comb begin
        fpc_d = fpc_q + 32'd4;
        if (exc_req) begin
            fpc_d = EXC_ENTRY;
        end else if (eret_req) begin
            fpc_d = epc;
        end else if (stall) begin
            fpc_d = fpc_q;
        end else if (br_en && branch) begin
            fpc_d = br_target;
        end else if (jump_en) begin
            fpc_d = jump_target;
        end else if (jr_en) begin
            fpc_d = jr_target;
        end
    end

    always_comb begin
        dpc_d    = dpc_q;
        dinstr_d = dinstr_q;
        dbd_d    = dbd_q;
        dexc_d   = dexc_q;
        if (flush) begin
            // Bubble carries the new fetch PC so a later EPC capture stays meaningful.
            dpc_d    = fpc_d;
            dinstr_d = 32'd0;
            dbd_d    = 1'b0;
            dexc_d   = EXC_NONE;
        end else if (!hold) begin
            dpc_d = fpc_q;
            dbd_d = br_en | jump_en | jr_en;
            if (fetch_fault) begin
                dinstr_d = 32'd0;
                dexc_d   = EXC_ADEL;
            end else begin
                dinstr_d = instr_F;
                dexc_d   = EXC_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc_q    <= RESET_PC;
            dpc_q    <= 32'd0;
            dinstr_q <= 32'd0;
            dbd_q    <= 1'b0;
            dexc_q   <= EXC_NONE;
        end else begin
            fpc_q    <= fpc_d;
            dpc_q    <= dpc_d;
            dinstr_q <= dinstr_d;
            dbd_q    <= dbd_d;
            dexc_q   <= dexc_d;
        end
    end

    always_comb begin
        pc_F    = fpc_q;
        pc_D    = dpc_q;
        pc8_D   = dpc_q + 32'd8;
        instr_D = dinstr_q;
        bd_D    = dbd_q;
        exc_D   = dexc_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] taken_q, stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_q <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (redirect) taken_q <= taken_q + 32'd1;
            if (hold)     stall_q <= stall_q + 32'd1;
        end
    end

    assign taken_cnt = taken_q;
    assign stall_cnt = stall_q;
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit with a scoreboard queue of expected D/F state.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] instr_F;
    logic        br_en;
    logic        branch;
    logic [15:0] br_off;
    logic        jump_en;
    logic [25:0] jump_idx;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc_F, pc_D, pc8_D, instr_D;
    logic        bd_D;
    logic [4:0]  exc_D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] taken_cnt, stall_cnt;
`endif

    fetch_pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .instr_F   (instr_F),
        .br_en     (br_en),
        .branch    (branch),
        .br_off    (br_off),
        .jump_en   (jump_en),
        .jump_idx  (jump_idx),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .pc_F      (pc_F),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .instr_D   (instr_D),
        .bd_D      (bd_D),
        .exc_D     (exc_D)
`ifdef FETCH_PERF_CNT_EN
        ,
        .taken_cnt (taken_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctl;    // {stall, br_en, branch, jump_en, jr_en, exc_req, eret_req}
        logic [31:0] opnd;   // br_off / jump_idx / jr_target / epc
        logic [31:0] instr;
        logic [31:0] e_pcf;
        logic [31:0] e_pcd;
        logic [31:0] e_instr;
        logic        e_bd;
        logic [4:0]  e_exc;
    } vec_t;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
    } exp_t;

    localparam logic [6:0] PL = 7'b000_0000;
    localparam logic [6:0] BT = 7'b011_0000;
    localparam logic [6:0] BN = 7'b010_0000;
    localparam logic [6:0] SB = 7'b111_0000;
    localparam logic [6:0] JP = 7'b000_1000;
    localparam logic [6:0] JR = 7'b000_0100;
    localparam logic [6:0] SX = 7'b100_0010;
    localparam logic [6:0] ER = 7'b000_0001;
    localparam logic [6:0] XE = 7'b000_0011;
    localparam logic [6:0] BJ = 7'b011_1000;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] opnd,
                                input logic [31:0] instr, input logic [31:0] e_pcf,
                                input logic [31:0] e_pcd, input logic [31:0] e_instr,
                                input logic e_bd, input logic [4:0] e_exc);
        vec_t v;
        v.ctl = ctl; v.opnd = opnd; v.instr = instr;
        v.e_pcf = e_pcf; v.e_pcd = e_pcd; v.e_instr = e_instr;
        v.e_bd = e_bd; v.e_exc = e_exc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        {stall, br_en, branch, jump_en, jr_en, exc_req, eret_req} = v.ctl;
        br_off    = v.opnd[15:0];
        jump_idx  = v.opnd[25:0];
        jr_target = v.opnd;
        epc       = v.opnd;
        instr_F   = v.instr;
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, " pc_F"},    pc_F,    e.pcf);
        check({tag, " pc_D"},    pc_D,    e.pcd);
        check({tag, " pc8_D"},   pc8_D,   e.pcd + 32'd8);
        check({tag, " instr_D"}, instr_D, e.instr);
        check({tag, " bd_D"},    {31'd0, bd_D},  {31'd0, e.bd});
        check({tag, " exc_D"},   {27'd0, exc_D}, {27'd0, e.exc});
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e;
        e.pcf = 32'h0000_3000; e.pcd = 32'd0; e.instr = 32'd0; e.bd = 1'b0; e.exc = 5'd0;
        compare(tag, e);
`ifdef FETCH_PERF_CNT_EN
        check({tag, " taken_cnt"}, taken_cnt, 32'd0);
        check({tag, " stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vec_t v;
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0001, 32'h3004, 32'h3000, 32'h2408_0001, 0, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0002, 32'h3008, 32'h3004, 32'h2408_0002, 0, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0003, 32'h300c, 32'h3008, 32'h2408_0003, 0, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0004, 32'h3010, 32'h300c, 32'h2408_0004, 0, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0005, 32'h3014, 32'h3010, 32'h2408_0005, 0, 0));
        tbl.push_back(mk(BT, 32'hfffc,   32'h2408_0006, 32'h3004, 32'h3014, 32'h2408_0006, 1, 0));
        tbl.push_back(mk(BN, 32'hfffc,   32'h2408_0007, 32'h3008, 32'h3004, 32'h2408_0007, 1, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0008, 32'h300c, 32'h3008, 32'h2408_0008, 0, 0));
        tbl.push_back(mk(SB, 32'h0004,   32'h2408_0009, 32'h300c, 32'h3008, 32'h2408_0008, 0, 0));
        tbl.push_back(mk(SB, 32'h0004,   32'h2408_000a, 32'h300c, 32'h3008, 32'h2408_0008, 0, 0));
        tbl.push_back(mk(SB, 32'h0004,   32'h2408_000b, 32'h300c, 32'h3008, 32'h2408_0008, 0, 0));
        tbl.push_back(mk(BT, 32'h0004,   32'h2408_000c, 32'h301c, 32'h300c, 32'h2408_000c, 1, 0));
        tbl.push_back(mk(JP, 32'h0c10,   32'h2408_000d, 32'h3040, 32'h301c, 32'h2408_000d, 1, 0));
        tbl.push_back(mk(SX, 32'h0,      32'h2408_000e, 32'h4180, 32'h4180, 32'h0,         0, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_000f, 32'h4184, 32'h4180, 32'h2408_000f, 0, 0));
        tbl.push_back(mk(ER, 32'h3020,   32'h2408_0010, 32'h3020, 32'h3020, 32'h0,         0, 0));
        tbl.push_back(mk(JR, 32'h3002,   32'h2408_0011, 32'h3002, 32'h3020, 32'h2408_0011, 1, 0));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0012, 32'h3006, 32'h3002, 32'h0,         0, 4));
        tbl.push_back(mk(JR, 32'h7000,   32'h2408_0013, 32'h7000, 32'h3006, 32'h0,         1, 4));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0014, 32'h7004, 32'h7000, 32'h0,         0, 4));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0015, 32'h7008, 32'h7004, 32'h0,         0, 4));
        tbl.push_back(mk(JR, 32'h6ffc,   32'h2408_0016, 32'h6ffc, 32'h7008, 32'h0,         1, 4));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0017, 32'h7000, 32'h6ffc, 32'h2408_0017, 0, 0));
        tbl.push_back(mk(JR, 32'h2ffc,   32'h2408_0018, 32'h2ffc, 32'h7000, 32'h0,         1, 4));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_0019, 32'h3000, 32'h2ffc, 32'h0,         0, 4));
        tbl.push_back(mk(PL, 32'h0,      32'h2408_001a, 32'h3004, 32'h3000, 32'h2408_001a, 0, 0));
        tbl.push_back(mk(XE, 32'h3020,   32'h2408_001b, 32'h4180, 32'h4180, 32'h0,         0, 0));
        tbl.push_back(mk(BJ, 32'h0002,   32'h2408_001c, 32'h418c, 32'h4180, 32'h2408_001c, 1, 0));

        reset = 1'b0;
        v = mk(PL, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        drive(v);
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            e.pcf = tbl[i].e_pcf; e.pcd = tbl[i].e_pcd; e.instr = tbl[i].e_instr;
            e.bd = tbl[i].e_bd; e.exc = tbl[i].e_exc;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("row%0d scoreboard empty", i), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                compare($sformatf("row%0d", i), e);
            end
        end

`ifdef FETCH_PERF_CNT_EN
        check("taken_cnt", taken_cnt, 32'd8);
        check("stall_cnt", stall_cnt, 32'd3);
`endif

        // Reset between edges must take effect without a clock.
        v = mk(PL, 32'h0, 32'h2408_001d, 0, 0, 0, 0, 0);
        drive(v);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b1;
        e.pcf = 32'h3004; e.pcd = 32'h3000; e.instr = 32'h2408_001d; e.bd = 1'b0; e.exc = 5'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare("after_midreset", e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- PC register plus IF/ID pipeline register of the five-stage MIPS core.
- Consumes the D-stage branch decision from the branch comparator, plus jump/jr/exception/eret redirects, and produces the next fetch PC.
- Latches the fetched instruction and its metadata (PC, delay-slot flag, fetch exception code) into D.
- Decision is made in D: the instruction in F when the redirect occurs is the delay slot and always proceeds.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset
EXC_ENTRY, 32'h0000_4180, exception handler entry
IMEM_LO, 32'h0000_3000, lowest legal fetch address
IMEM_HI, 32'h0000_6ffc, highest legal fetch address

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hazard stall: hold PC and IF/ID
instr_F  in  32  instruction word read at pc_F
br_en  in  1  D-stage instruction is a conditional branch
branch  in  1  comparator result for the D-stage branch
br_off  in  16  D-stage branch immediate
jump_en  in  1  D-stage j/jal
jump_idx  in  26  D-stage jump index
jr_en  in  1  D-stage jr/jalr
jr_target  in  32  forwarded rs value
exc_req  in  1  CP0 exception/interrupt taken this cycle
eret_req  in  1  eret in D
epc  in  32  CP0 EPC
pc_F  out  32  current fetch address
pc_D  out  32  PC of D-stage instruction
pc8_D  out  32  pc_D+8, link address (combinational)
instr_D  out  32  D-stage instruction
bd_D  out  1  D instruction sits in a delay slot
exc_D  out  5  fetch exception code (0 none, 4 AdEL)

Behaviour:
- Reset low (async): pc_F=RESET_PC; pc_D=0; instr_D=0; bd_D=0; exc_D=0. First rising edge after release fetches RESET_PC+4 unless stalled.
- Targets, all 32-bit with wrap-around:
  - branch: pc_D+4+(sext(br_off)<<2)
  - jump: {pc_D[31:28]+carry of pc_D+4, jump_idx, 2'b00}, i.e. upper 4 bits of pc_D+4
  - jr: jr_target
- Next-PC priority, registered on the rising edge:
  1. exc_req → EXC_ENTRY
  2. eret_req → epc
  3. stall → hold
  4. br_en&branch → branch target
  5. jump_en → jump target
  6. jr_en → jr_target
  7. otherwise pc_F+4
- br_en with branch=0 gives pc_F+4.
- exc_req and eret_req override stall.
- IF/ID update, same edge:
  - exc_req or eret_req: flush. instr_D=0, bd_D=0, exc_D=0, pc_D=next pc_F value (keeps EPC sane for bubble).
  - else stall: all D outputs hold.
  - else capture:
    - pc_D=pc_F
    - bd_D=br_en|jump_en|jr_en, set regardless of taken
    - if pc_F[1:0]!=0 or pc_F<IMEM_LO or pc_F>IMEM_HI: exc_D=5'd4, instr_D=0
    - else exc_D=0, instr_D=instr_F
- Misaligned/out-of-range targets are loaded into pc_F unchanged; the fault is reported only via exc_D one cycle later.
- Simultaneous br_en and jump_en cannot occur, since decode is one-hot. Priority order above is still mandatory.
- Reset asserted mid-operation overrides everything immediately, with no clock edge needed.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs taken_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - taken_cnt increments on each edge where a branch/jump/jr redirect is applied (not under stall/exc/eret).
  - stall_cnt increments on each edge with stall=1 and no exc_req/eret_req.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset low, then release, no stall, instr_F=32'h2408_0001 → pc_F 3000→3004→3008; after the first edge pc_D=3000, instr_D=24080001, exc_D=0, bd_D=0.
- pc_D=3010, br_en=1, branch=1, br_off=16'hfffc → next pc_F=3004; captured pc_D=pc_F old with bd_D=1; with branch=0 → pc_F+4 and bd_D still 1.
- stall=1 for 3 cycles with br_en=1, branch=1 → pc_F, pc_D, instr_D frozen; redirect applied on the first edge after stall drops (FETCH_PERF_CNT_EN: stall_cnt=3, taken_cnt=1).
- exc_req=1 while stall=1 → pc_F=4180, instr_D=0, bd_D=0; eret_req with epc=3020 → pc_F=3020, D flushed.
- jr_en=1, jr_target=3002 → pc_F=3002; the next capture gives exc_D=4, instr_D=0. Repeat with jr_target=7000 → exc_D=4.
- Assert reset mid-stream between edges → outputs return to reset values immediately.
